// File: rtl/riscv_fetch_req_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_fetch_req_ctrl
//
// Instruction-memory request engine that sits directly in front of the fetch
// FIFO. It keeps at most one req/gnt/rvalid transaction outstanding, pushes
// every returned word into the FIFO together with its fetch address, and
// handles two kinds of redirect:
//   - branch:  clears the FIFO, drops any word still in flight and restarts
//              fetching at the (halfword aligned) target.
//   - hw-loop: the word already in flight is still pushed; the next request
//              goes to the loop target and its word is tagged replace2/is_hwlp.
//
// Ports
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   req_i             fetch enable, gates new requests only
//   branch_i          branch redirect pulse (highest priority)
//   branch_addr_i     branch target, bit0 ignored
//   hwlp_branch_i     hardware-loop redirect pulse
//   hwlp_target_i     hardware-loop target, bit0 ignored
//   instr_req_o       memory request
//   instr_addr_o      word-aligned memory address
//   instr_gnt_i       memory accepted the request
//   instr_rvalid_i    read data valid
//   instr_rdata_i     read data
//   fifo_clear_o      FIFO flush (follows branch_i combinationally)
//   fifo_valid_o      one-cycle push strobe
//   fifo_addr_o       fetch address of the pushed word (bit1 kept after redirect)
//   fifo_rdata_o      pushed word
//   fifo_ready_i      FIFO can accept one more word
//   fifo_replace2_o   pushed word replaces FIFO entry 1
//   fifo_is_hwlp_o    pushed word is the hardware-loop target
//   busy_o            engine is not idle
// -----------------------------------------------------------------------------
module riscv_fetch_req_ctrl #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        hwlp_branch_i,
  input  logic [31:0] hwlp_target_i,

  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,

  output logic        fifo_clear_o,
  output logic        fifo_valid_o,
  output logic [31:0] fifo_addr_o,
  output logic [31:0] fifo_rdata_o,
  input  logic        fifo_ready_i,
  output logic        fifo_replace2_o,
  output logic        fifo_is_hwlp_o,

  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_GNT     = 2'd1,
    WAIT_RVALID  = 2'd2,
    WAIT_ABORTED = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q,       state_d;
  // Address of the outstanding request while one is in flight, otherwise the
  // address the next request will use. Bit1 survives a redirect so the first
  // pushed word carries the exact halfword target.
  logic [31:0] fetch_addr_q,  fetch_addr_d;
  // Branch taken while a request waits for its grant: the request address must
  // stay stable, so the target is parked here until the grant arrives.
  logic        branch_pend_q, branch_pend_d;
  logic [31:0] pend_addr_q,   pend_addr_d;
  // Hardware-loop target waiting for the next request slot.
  logic        hwlp_pend_q,   hwlp_pend_d;
  logic [31:0] hwlp_addr_q,   hwlp_addr_d;
  // The outstanding request fetches the hardware-loop target word.
  logic        req_hwlp_q,    req_hwlp_d;
  // Low during reset and for the first cycle after release; silences all
  // outputs and freezes the engine for that cycle.
  logic        active_q;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  logic        can_issue;
  logic        hwlp_now;
  logic        issue_slot;
  logic [31:0] br_addr;
  logic [31:0] hwlp_in_addr;
  logic [31:0] hwlp_tgt;
  logic [31:0] seq_next;
  logic [31:0] seq_addr;
  logic [31:0] base_addr;

  assign can_issue    = req_i & fifo_ready_i;
  assign br_addr      = branch_addr_i & 32'hFFFF_FFFE;
  assign hwlp_in_addr = hwlp_target_i & 32'hFFFF_FFFE;
  // A same-cycle hwlp pulse is already usable for a request issued now; a
  // branch in the same cycle cancels it.
  assign hwlp_now     = (hwlp_pend_q | hwlp_branch_i) & ~branch_i;
  assign hwlp_tgt     = hwlp_branch_i ? hwlp_in_addr : hwlp_addr_q;
  // Next sequential word; wraps from 32'hFFFF_FFFC to 0.
  assign seq_next     = {fetch_addr_q[31:2] + 30'd1, 2'b00};

  assign busy_o       = active_q & (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d         = state_q;
    fetch_addr_d    = fetch_addr_q;
    branch_pend_d   = branch_pend_q;
    pend_addr_d     = pend_addr_q;
    hwlp_pend_d     = hwlp_pend_q;
    hwlp_addr_d     = hwlp_addr_q;
    req_hwlp_d      = req_hwlp_q;
    issue_slot      = 1'b0;
    seq_addr        = fetch_addr_q;
    base_addr       = fetch_addr_q;

    instr_req_o     = 1'b0;
    instr_addr_o    = '0;
    fifo_clear_o    = 1'b0;
    fifo_valid_o    = 1'b0;
    fifo_addr_o     = '0;
    fifo_rdata_o    = '0;
    fifo_replace2_o = 1'b0;
    fifo_is_hwlp_o  = 1'b0;

    if (active_q) begin
      fifo_clear_o = branch_i;

      // Redirect bookkeeping shared by all states.
      if (branch_i) begin
        hwlp_pend_d = 1'b0;
        req_hwlp_d  = 1'b0;
      end else if (hwlp_branch_i) begin
        hwlp_pend_d = 1'b1;
        hwlp_addr_d = hwlp_in_addr;
      end

      unique case (state_q)
        IDLE: begin
          issue_slot = 1'b1;
        end

        WAIT_GNT: begin
          // Request is never withdrawn and its address never changes.
          instr_req_o  = 1'b1;
          instr_addr_o = fetch_addr_q & 32'hFFFF_FFFC;
          if (instr_gnt_i) begin
            if (branch_pend_q || branch_i) begin
              // The granted word belongs to the old path; discard it.
              state_d      = WAIT_ABORTED;
              fetch_addr_d = branch_i ? br_addr : pend_addr_q;
            end else begin
              state_d = WAIT_RVALID;
            end
            branch_pend_d = 1'b0;
          end else if (branch_i) begin
            branch_pend_d = 1'b1;
            pend_addr_d   = br_addr;
          end
        end

        WAIT_RVALID: begin
          if (instr_rvalid_i) begin
            if (!branch_i) begin
              fifo_valid_o    = 1'b1;
              fifo_addr_o     = fetch_addr_q;
              fifo_rdata_o    = instr_rdata_i;
              fifo_replace2_o = req_hwlp_q;
              fifo_is_hwlp_o  = req_hwlp_q;
            end
            issue_slot = 1'b1;
            seq_addr   = seq_next;
          end else if (branch_i) begin
            state_d      = WAIT_ABORTED;
            fetch_addr_d = br_addr;
          end
        end

        WAIT_ABORTED: begin
          // fetch_addr_q already holds the redirect target.
          if (instr_rvalid_i) begin
            issue_slot = 1'b1;
          end else if (branch_i) begin
            fetch_addr_d = br_addr;
          end
        end

        default: state_d = IDLE;
      endcase

      // The transaction slot is free this cycle: issue the next request now
      // (back-to-back with the returning word) or fall back to IDLE.
      if (issue_slot) begin
        base_addr = branch_i ? br_addr : (hwlp_now ? hwlp_tgt : seq_addr);
        if (can_issue) begin
          instr_req_o  = 1'b1;
          instr_addr_o = base_addr & 32'hFFFF_FFFC;
          fetch_addr_d = base_addr;
          req_hwlp_d   = hwlp_now;
          hwlp_pend_d  = 1'b0;
          state_d      = instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
        end else begin
          fetch_addr_d = branch_i ? br_addr : seq_addr;
          state_d      = IDLE;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      fetch_addr_q  <= BOOT_ADDR;
      branch_pend_q <= 1'b0;
      pend_addr_q   <= '0;
      hwlp_pend_q   <= 1'b0;
      hwlp_addr_q   <= '0;
      req_hwlp_q    <= 1'b0;
      active_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      branch_pend_q <= branch_pend_d;
      pend_addr_q   <= pend_addr_d;
      hwlp_pend_q   <= hwlp_pend_d;
      hwlp_addr_q   <= hwlp_addr_d;
      req_hwlp_q    <= req_hwlp_d;
      active_q      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_fetch_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_riscv_fetch_req_ctrl
//
// Randomised bench for riscv_fetch_req_ctrl. A driver process plays the core,
// the FIFO and the instruction memory; after driving each cycle it advances a
// transaction-level reference model (outstanding request / word records with a
// discard flag) and queues the expected per-cycle control outputs and the
// expected FIFO pushes. A separate monitor process samples the DUT mid-cycle,
// pops the queues and compares.
// -----------------------------------------------------------------------------
module tb_riscv_fetch_req_ctrl;

  localparam int NUM_CYCLES = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        hwlp_branch_i = 1'b0;
  logic [31:0] hwlp_target_i = '0;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        fifo_clear_o;
  logic        fifo_valid_o;
  logic [31:0] fifo_addr_o;
  logic [31:0] fifo_rdata_o;
  logic        fifo_ready_i = 1'b0;
  logic        fifo_replace2_o;
  logic        fifo_is_hwlp_o;
  logic        busy_o;

  riscv_fetch_req_ctrl #(.BOOT_ADDR(32'h0000_0080)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .hwlp_branch_i  (hwlp_branch_i),
    .hwlp_target_i  (hwlp_target_i),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .fifo_clear_o   (fifo_clear_o),
    .fifo_valid_o   (fifo_valid_o),
    .fifo_addr_o    (fifo_addr_o),
    .fifo_rdata_o   (fifo_rdata_o),
    .fifo_ready_i   (fifo_ready_i),
    .fifo_replace2_o(fifo_replace2_o),
    .fifo_is_hwlp_o (fifo_is_hwlp_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        clear;
    logic        busy;
    logic        valid;
  } cyc_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        hw;
  } push_t;

  cyc_t  cyc_q[$];
  push_t push_q[$];
  int    tests = 0;
  int    fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one transaction slot, described as "a request waiting for
  // its grant" and "a granted word waiting for data", each tagged with its
  // fetch address, hwlp flag and whether a redirect has made it stale.
  // ---------------------------------------------------------------------------
  bit          m_en;
  logic [31:0] m_next;          // where sequential fetching continues
  bit          m_hw_pend;
  logic [31:0] m_hw_addr;
  bit          m_have_req;
  logic [31:0] m_req_addr;
  bit          m_req_hw, m_req_drop;
  bit          m_have_out;
  logic [31:0] m_out_addr;
  bit          m_out_hw, m_out_drop;
  int          mem_cd = 0;      // cycles until the memory returns data
  int          mem_delay = 1;   // latency given to the next granted request

  task automatic model_reset();
    m_en       = 1'b0;
    m_next     = 32'h0000_0080;
    m_hw_pend  = 1'b0;
    m_have_req = 1'b0;
    m_have_out = 1'b0;
  endtask

  task automatic model_step();
    cyc_t        e;
    push_t       p;
    bit          start_req, start_out, free;
    logic [31:0] a;
    bit          hw;
    e = '{req: 1'b0, addr: '0, clear: 1'b0, busy: 1'b0, valid: 1'b0};
    if (rst) begin
      model_reset();
      cyc_q.push_back(e);
      return;
    end
    if (!m_en) begin
      m_en = 1'b1;
      cyc_q.push_back(e);
      return;
    end
    e.clear   = branch_i;
    start_req = m_have_req;
    start_out = m_have_out;
    e.busy    = start_req || start_out;
    free      = !start_req && (!start_out || instr_rvalid_i);

    // Data for the granted word returns.
    if (start_out && instr_rvalid_i) begin
      m_have_out = 1'b0;
      if (!m_out_drop && !branch_i) begin
        p = '{addr: m_out_addr, data: instr_rdata_i, hw: m_out_hw};
        push_q.push_back(p);
        e.valid = 1'b1;
      end
      if (!m_out_drop) m_next = (m_out_addr & 32'hFFFF_FFFC) + 32'd4;
    end

    // Redirects.
    if (branch_i) begin
      m_next     = branch_addr_i & 32'hFFFF_FFFE;
      m_hw_pend  = 1'b0;
      m_out_drop = 1'b1;
      m_req_drop = 1'b1;
    end else if (hwlp_branch_i) begin
      m_hw_pend = 1'b1;
      m_hw_addr = hwlp_target_i & 32'hFFFF_FFFE;
    end

    // A request already on the bus stays there until granted.
    if (start_req) begin
      e.req  = 1'b1;
      e.addr = m_req_addr & 32'hFFFF_FFFC;
      if (instr_gnt_i) begin
        m_have_req = 1'b0;
        m_have_out = 1'b1;
        m_out_addr = m_req_addr;
        m_out_hw   = m_req_hw;
        m_out_drop = m_req_drop;
        mem_cd     = mem_delay;
      end
    end

    // New request when the slot is free and the core/FIFO allow it.
    if (free && req_i && fifo_ready_i) begin
      a         = m_hw_pend ? m_hw_addr : m_next;
      hw        = m_hw_pend;
      m_hw_pend = 1'b0;
      e.req     = 1'b1;
      e.addr    = a & 32'hFFFF_FFFC;
      if (instr_gnt_i) begin
        m_have_out = 1'b1;
        m_out_addr = a;
        m_out_hw   = hw;
        m_out_drop = 1'b0;
        mem_cd     = mem_delay;
      end else begin
        m_have_req = 1'b1;
        m_req_addr = a;
        m_req_hw   = hw;
        m_req_drop = 1'b0;
      end
    end
    cyc_q.push_back(e);
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0:       r = 32'h0000_1002;
      1:       r = 32'hFFFF_FFF8;
      2:       r = 32'h0000_0200 + 32'($urandom_range(0, 31));
      default: r = $urandom;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  initial begin
    model_reset();
    for (int c = 0; c < NUM_CYCLES; c++) begin
      bit quiet, calm;
      @(negedge clk);
      quiet = (c < 40);               // plain sequential fetch, 1-cycle memory
      calm  = (c > 40 && c < 80);     // no redirects while crossing the wrap
      rst   = (c < 2) || (c >= 600 && c < 602) || (c >= 1800 && c < 1801);

      req_i         = quiet ? 1'b1 : ($urandom_range(0, 9) != 0);
      fifo_ready_i  = quiet ? 1'b1 : ($urandom_range(0, 4) != 0);
      instr_gnt_i   = quiet ? 1'b1 : ($urandom_range(0, 9) < 6);
      mem_delay     = quiet ? 1 : int'($urandom_range(1, 3));
      branch_i      = (c == 40) ? 1'b1 :
                      (quiet || calm) ? 1'b0 : ($urandom_range(0, 15) == 0);
      branch_addr_i = (c == 40) ? 32'hFFFF_FFF7 : pick_addr();
      hwlp_branch_i = (c == 20) ? 1'b1 :
                      (quiet || calm) ? 1'b0 : ($urandom_range(0, 19) == 0);
      hwlp_target_i = (c == 20) ? 32'h0000_0200 : pick_addr();
      instr_rdata_i = $urandom;

      // Memory: return data after the granted latency; otherwise an occasional
      // stray rvalid with nothing granted (also covers late data after reset).
      if (mem_cd > 0) begin
        mem_cd--;
        instr_rvalid_i = (mem_cd == 0);
      end else begin
        instr_rvalid_i = !m_have_out && ($urandom_range(0, 19) == 0);
      end

      model_step();
    end
    @(negedge clk);
    #5;
    check("pending_pushes", 32'(push_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    cyc_t  e;
    push_t p;
    forever begin
      @(negedge clk);
      #2;
      if (cyc_q.size() != 0) begin
        e = cyc_q.pop_front();
        check("instr_req_o", {31'b0, instr_req_o}, {31'b0, e.req});
        if (e.req) check("instr_addr_o", instr_addr_o, e.addr);
        check("fifo_clear_o", {31'b0, fifo_clear_o}, {31'b0, e.clear});
        check("busy_o", {31'b0, busy_o}, {31'b0, e.busy});
        check("fifo_valid_o", {31'b0, fifo_valid_o}, {31'b0, e.valid});
        if (fifo_valid_o) begin
          if (push_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL push_unexpected at %0t: got push addr %h, expected no push",
                     $time, fifo_addr_o);
          end else begin
            p = push_q.pop_front();
            check("fifo_addr_o", fifo_addr_o, p.addr);
            check("fifo_rdata_o", fifo_rdata_o, p.data);
            check("fifo_replace2_o", {31'b0, fifo_replace2_o}, {31'b0, p.hw});
            check("fifo_is_hwlp_o", {31'b0, fifo_is_hwlp_o}, {31'b0, p.hw});
          end
        end
      end
    end
  end

endmodule
